// File: rtl/vericlock_set_ctrl_if.sv
// Button inputs and setting-mode outputs of the vericlock set controller.
interface vericlock_set_ctrl_if;
   logic       btn_mode;
   logic       btn_up;
   logic       inc_sec;
   logic       inc_min;
   logic       inc_hour;
   logic       inc_day;
   logic       inc_month;
   logic       inc_year;
   logic [2:0] field_sel;
   logic       set_mode;
   logic       blink;
   logic       hold_time;

   modport master (
      output btn_mode, btn_up,
      input  inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year,
      input  field_sel, set_mode, blink, hold_time
   );

   modport slave (
      input  btn_mode, btn_up,
      output inc_sec, inc_min, inc_hour, inc_day, inc_month, inc_year,
      output field_sel, set_mode, blink, hold_time
   );
endinterface

// File: rtl/vericlock_set_ctrl.sv
// vericlock time/date setting controller: button debounce, field-select FSM,
// increment pulses with auto-repeat, inactivity timeout and field blink.
module vericlock_set_ctrl #(
   parameter int DEBOUNCE_CYCLES     = 2_000_000,
   parameter int REPEAT_DELAY_CYCLES = 50_000_000,
   parameter int REPEAT_RATE_CYCLES  = 10_000_000,
   parameter int TIMEOUT_CYCLES      = 1_000_000_000,
   parameter int BLINK_CYCLES        = 25_000_000
) (
   input logic                 clk_100MHz,
   input logic                 reset,
   vericlock_set_ctrl_if.slave bus
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                         REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW   = $clog2(BLINK_CYCLES + 1);
   localparam int NB   = 2;  // button index: 0 = mode, 1 = up

   typedef enum logic [2:0] {
      RUN = 3'd0, HOUR = 3'd1, MIN = 3'd2, SEC = 3'd3,
      DAY = 3'd4, MONTH = 3'd5, YEAR = 3'd6
   } state_t;

   logic [NB-1:0]         raw, sync1, sync2, db, db_q;
   logic [NB-1:0][DW-1:0] db_cnt;
   logic [1:0]            settle;
   logic                  up_arm;
   state_t                state, state_nxt;
   logic                  rep_active, rep_fast;
   logic [HW-1:0]         hold_cnt;
   logic [TW-1:0]         inact_cnt;
   logic [BW-1:0]         blink_cnt;
   logic                  blink_q, set_mode_q, hold_time_q;
   logic [5:0]            inc_q;  // [0]=hour .. [5]=year, same order as field_sel-1
   logic                  mode_ev, up_ev, set_st, up_ok, rep_ev, fire, activity, timeout;

   assign raw = {bus.btn_up, bus.btn_mode};

   // Two-flop synchronizer and stability counter per button.
   always_ff @(posedge clk_100MHz) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         db_q   <= '0;
         db_cnt <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         db_q  <= db;
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // An up button held through reset must be seen released before it counts;
   // settle waits until sync2 carries a real post-reset sample.
   always_ff @(posedge clk_100MHz) begin
      if (!reset) begin
         settle <= '0;
         up_arm <= 1'b0;
      end else begin
         if (settle != 2'd2) settle <= settle + 2'd1;
         if (settle == 2'd2 && !db[1] && !sync2[1]) up_arm <= 1'b1;
      end
   end

   assign mode_ev  = db[0] & ~db_q[0];
   assign up_ev    = db[1] & ~db_q[1] & up_arm;
   assign set_st   = (state != RUN);
   assign up_ok    = up_ev & ~mode_ev & set_st;
   assign rep_ev   = rep_active & db[1] &
                     (hold_cnt == (rep_fast ? HW'(REPEAT_RATE_CYCLES) : HW'(REPEAT_DELAY_CYCLES)));
   assign fire     = set_st & ~mode_ev & (up_ok | rep_ev);
   assign activity = mode_ev | (up_ev & set_st) | rep_ev;
   assign timeout  = set_st & ~activity & (inact_cnt == TW'(TIMEOUT_CYCLES));

   // Next field: mode press steps (YEAR wraps to RUN), else inactivity drops to RUN.
   always_comb begin
      state_nxt = state;
      if (mode_ev)      state_nxt = (state == YEAR) ? RUN : state_t'(state + 3'd1);
      else if (timeout) state_nxt = RUN;
   end

   // FSM state, registered outputs, repeat/timeout/blink counters.
   always_ff @(posedge clk_100MHz) begin
      if (!reset) begin
         state       <= RUN;
         set_mode_q  <= 1'b0;
         hold_time_q <= 1'b0;
         inc_q       <= '0;
         rep_active  <= 1'b0;
         rep_fast    <= 1'b0;
         hold_cnt    <= '0;
         inact_cnt   <= '0;
         blink_q     <= 1'b0;
         blink_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         set_mode_q  <= (state_nxt != RUN);
         hold_time_q <= (state_nxt == SEC);
         inc_q       <= fire ? (6'b1 << (state - 3'd1)) : 6'b0;

         // Repeat is armed only by an accepted press; a field change kills it
         // until btn_up is released and pressed again.
         if (mode_ev || !db[1] || state_nxt == RUN) begin
            rep_active <= 1'b0;
            rep_fast   <= 1'b0;
            hold_cnt   <= '0;
         end else if (up_ok) begin
            rep_active <= 1'b1;
            rep_fast   <= 1'b0;
            hold_cnt   <= HW'(1);
         end else if (rep_ev) begin
            rep_fast   <= 1'b1;
            hold_cnt   <= HW'(1);
         end else if (rep_active) begin
            hold_cnt   <= hold_cnt + 1'b1;
         end

         // inact_cnt holds cycles since the last activity; it never passes TIMEOUT.
         if (state_nxt == RUN) inact_cnt <= '0;
         else if (activity)    inact_cnt <= TW'(1);
         else                  inact_cnt <= inact_cnt + 1'b1;

         if (state_nxt == RUN) begin
            blink_q   <= 1'b0;
            blink_cnt <= '0;
         end else if (state_nxt != state) begin
            blink_q   <= 1'b1;
            blink_cnt <= '0;
         end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_q   <= ~blink_q;
            blink_cnt <= '0;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign bus.field_sel = state;
   assign bus.set_mode  = set_mode_q;
   assign bus.hold_time = hold_time_q;
   assign bus.blink     = blink_q;
   assign bus.inc_hour  = inc_q[0];
   assign bus.inc_min   = inc_q[1];
   assign bus.inc_sec   = inc_q[2];
   assign bus.inc_day   = inc_q[3];
   assign bus.inc_month = inc_q[4];
   assign bus.inc_year  = inc_q[5];
endmodule

// File: tb/tb_vericlock_set_ctrl.sv
// Bench for vericlock_set_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a cycle-count based behavioural model.
module tb_vericlock_set_ctrl;
   localparam int DB = 4, DLY = 20, RATE = 5, TMO = 100, BLK = 8;

   logic clk = 1'b0;
   logic rst;
   vericlock_set_ctrl_if bus();

   vericlock_set_ctrl #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY_CYCLES(DLY), .REPEAT_RATE_CYCLES(RATE),
      .TIMEOUT_CYCLES(TMO), .BLINK_CYCLES(BLK)
   ) dut (
      .clk_100MHz(clk),
      .reset     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   // model: raw sample history ([0] newest), debounced levels, field and timing marks
   logic [DB:0] hm, hu;
   logic        mdb_m, mdb_u, mdbq_m, mdbq_u, arm, rep_on;
   int          k, since, fsel, last_act, press_k, entry_k;
   logic [5:0]  e_inc;
   logic        e_blink;

   // observation counters for directed checks
   int n_inc, n_blink4;
   int n_fld [6];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_step(input logic r, input logic m, input logic u);
      logic mev, uev, up_ok, rep, act, set;
      int   nxt, off;
      k++;
      if (!r) begin
         hm = '0; hu = '0;
         mdb_m = 0; mdb_u = 0; mdbq_m = 0; mdbq_u = 0;
         arm = 0; since = 0; fsel = 0; rep_on = 0;
         e_inc = '0; e_blink = 0;
      end else begin
         mev   = mdb_m && !mdbq_m;
         uev   = mdb_u && !mdbq_u && arm;
         set   = (fsel != 0);
         up_ok = uev && !mev && set;
         off   = k - press_k;
         rep   = rep_on && mdb_u && (off >= DLY) && ((off - DLY) % RATE == 0);
         act   = mev || (uev && set) || rep;
         e_inc = '0;
         if (set && !mev && (up_ok || rep)) e_inc[fsel-1] = 1'b1;
         nxt = fsel;
         if (mev) nxt = (fsel + 1) % 7;
         else if (set && !act && (k - last_act == TMO)) nxt = 0;
         if (act) last_act = k;
         if (mev || !mdb_u || nxt == 0) rep_on = 0;
         else if (up_ok) begin
            rep_on  = 1;
            press_k = k;
         end
         if (nxt != 0 && nxt != fsel) entry_k = k;
         fsel    = nxt;
         e_blink = (fsel != 0) && (((k - entry_k) / BLK) % 2 == 0);
         // up counts only after a released level is seen on real post-reset samples
         if (since >= 2 && !hu[1] && !mdb_u) arm = 1;
         mdbq_m = mdb_m;
         mdbq_u = mdb_u;
         // debounced level follows once the last DB synchronized samples all disagree
         if (hm[DB:1] == {DB{~mdb_m}}) mdb_m = ~mdb_m;
         if (hu[DB:1] == {DB{~mdb_u}}) mdb_u = ~mdb_u;
         hm = {hm[DB-1:0], m};
         hu = {hu[DB-1:0], u};
         if (since < 2) since++;
      end
   endtask

   task automatic tick(input logic r, input logic m, input logic u);
      logic [11:0] got, exp;
      rst          = r;
      bus.btn_mode = m;
      bus.btn_up   = u;
      @(posedge clk);
      #1;
      model_step(r, m, u);
      got = {bus.inc_year, bus.inc_month, bus.inc_day, bus.inc_sec, bus.inc_min, bus.inc_hour,
             bus.field_sel, bus.set_mode, bus.blink, bus.hold_time};
      exp = {e_inc, fsel[2:0], fsel != 0, e_blink, fsel == 3};
      chk("outs", 32'(got), 32'(exp));
      if (|got[11:6]) n_inc++;
      for (int i = 0; i < 6; i++) if (got[6+i]) n_fld[i]++;
      if (bus.field_sel == 3'd4 && bus.blink) n_blink4++;
   endtask

   task automatic run(input int n, input logic m, input logic u);
      repeat (n) tick(1'b1, m, u);
   endtask

   task automatic mode_press();
      run(10, 1'b1, 1'b0);
      run(10, 1'b0, 1'b0);
   endtask

   task automatic clr_cnt();
      n_inc = 0;
      for (int i = 0; i < 6; i++) n_fld[i] = 0;
   endtask

   initial begin
      // reset, then up in RUN is ignored
      repeat (10) tick(1'b0, 1'b0, 1'b0);
      chk("rst_fsel", 32'(bus.field_sel), 0);
      chk("rst_blink", 32'(bus.blink), 0);
      run(5, 1'b0, 1'b0);
      clr_cnt();
      run(10, 1'b0, 1'b1);
      run(10, 1'b0, 1'b0);
      chk("run_up_no_inc", n_inc, 0);

      // mode steps to SEC; glitch ignored; clean press gives one inc_sec
      for (int i = 1; i <= 3; i++) begin
         mode_press();
         chk("fsel_step", 32'(bus.field_sel), i);
         chk("hold_time", 32'(bus.hold_time), 32'(i == 3));
      end
      clr_cnt();
      run(2, 1'b0, 1'b1);
      run(10, 1'b0, 1'b0);
      chk("glitch_no_inc", n_inc, 0);
      clr_cnt();
      run(10, 1'b0, 1'b1);
      run(10, 1'b0, 1'b0);
      chk("sec_one_pulse", n_fld[2], 1);
      chk("sec_only", n_inc, 1);

      // HOUR auto-repeat over a 45-cycle hold
      repeat (5) mode_press();
      chk("at_hour", 32'(bus.field_sel), 1);
      clr_cnt();
      run(45, 1'b0, 1'b1);
      run(10, 1'b0, 1'b0);
      chk("rep_hour", n_fld[0], 6);
      chk("rep_only_hour", n_inc, 6);

      // simultaneous mode+up in MIN: mode wins, no pulse
      mode_press();
      chk("at_min", 32'(bus.field_sel), 2);
      clr_cnt();
      run(10, 1'b1, 1'b1);
      run(10, 1'b0, 1'b0);
      chk("simul_fsel", 32'(bus.field_sel), 3);
      chk("simul_no_inc", n_inc, 0);
      repeat (4) mode_press();
      chk("back_run", 32'(bus.field_sel), 0);
      for (int i = 1; i <= 7; i++) begin
         mode_press();
         chk("mode_seq", 32'(bus.field_sel), i % 7);
      end

      // DAY: blink cadence and inactivity timeout
      repeat (3) mode_press();
      n_blink4 = 0;
      mode_press();
      chk("at_day", 32'(bus.field_sel), 4);
      run(110, 1'b0, 1'b0);
      chk("tmo_fsel", 32'(bus.field_sel), 0);
      chk("tmo_blink", 32'(bus.blink), 0);
      chk("blink_on", n_blink4, 52);

      // YEAR: reset while repeating, then recovery from RUN
      repeat (6) mode_press();
      chk("at_year", 32'(bus.field_sel), 6);
      clr_cnt();
      run(30, 1'b0, 1'b1);
      chk("year_rep", n_fld[5], 2);
      clr_cnt();
      tick(1'b0, 1'b0, 1'b1);
      chk("rst_mid_fsel", 32'(bus.field_sel), 0);
      tick(1'b1, 1'b0, 1'b1);
      chk("rst_mid_no_inc", n_inc, 0);
      run(15, 1'b0, 1'b1);
      run(10, 1'b0, 1'b0);
      chk("held_no_event", n_inc, 0);
      mode_press();
      chk("resume_fsel", 32'(bus.field_sel), 1);
      clr_cnt();
      run(10, 1'b0, 1'b1);
      run(10, 1'b0, 1'b0);
      chk("resume_inc", n_fld[0], 1);

      // random traffic, model-checked every cycle
      for (int it = 0; it < 150; it++) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 4)
            repeat ($urandom_range(1, 3)) tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else if (sel < 10)
            run(int'($urandom_range(100, 130)), 1'b0, 1'b0);
         else
            run(int'($urandom_range(1, 30)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
